// File: rtl/instruction_fetch.sv
// instruction_fetch: BOOT/RUN/FLUSH fetch stage feeding decode.
// Define IF_PREDECODE_JMP_EN to resolve JMP targets in fetch.
`ifndef OPC_NOP
`define OPC_NOP 4'h0
`endif
`ifndef OPC_JMP
`define OPC_JMP 4'h9
`endif

module instruction_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        iStall,
  input  logic        iBranchTaken,
  input  logic [15:0] iBranchTarget,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  output logic [27:0] oInstruction,
  output logic [15:0] oPC,
  output logic        oValid
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [27:0] NOP_IR = {`OPC_NOP, 24'd0};

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] pc_next;

  always_comb begin
    pc_next = pc + 16'd1;
`ifdef IF_PREDECODE_JMP_EN
    if (iInstruction[27:24] == `OPC_JMP)
      pc_next = {8'd0, iInstruction[23:16]};
`endif
  end

  assign oAddress = pc;

  // Arms are ordered by priority: boot, redirect, flush, stall, fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= 16'd0;
      oPC          <= 16'd0;
      oValid       <= 1'b0;
      oInstruction <= NOP_IR;
    end else begin
      priority case (1'b1)
        (state == BOOT): begin
          state <= RUN;
        end
        iBranchTaken: begin
          pc           <= iBranchTarget;
          oValid       <= 1'b0;
          oInstruction <= NOP_IR;
          state        <= FLUSH;
        end
        (state == FLUSH): begin
          state <= RUN;
        end
        iStall: begin
        end
        default: begin
          oInstruction <= iInstruction;
          oPC          <= pc;
          oValid       <= 1'b1;
          pc           <= pc_next;
          state        <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch sequencing,
// stall, redirect, wrap and asynchronous reset.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic [15:0] oPC;
  logic        oValid;

  int total = 0;
  int bad   = 0;

  localparam logic [27:0] NOP_IR = 28'h0000000;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .iStall       (iStall),
    .iBranchTaken (iBranchTaken),
    .iBranchTarget(iBranchTarget),
    .oAddress     (oAddress),
    .iInstruction (iInstruction),
    .oInstruction (oInstruction),
    .oPC          (oPC),
    .oValid       (oValid)
  );

  always #5 clk = ~clk;

  // Program: word 7 is JMP 3, every other word is a tagged ALU op.
  function automatic logic [27:0] mem(input logic [15:0] a);
    if (a == 16'd7) return {4'h9, 8'd3, 16'h0000};
    return {4'h1, a[7:0] ^ 8'h5A, a[15:8], a[7:0]};
  endfunction

  always_comb iInstruction = mem(oAddress);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [15:0] tgt);
    iBranchTaken  = 1'b1;
    iBranchTarget = tgt;
    step();
    iBranchTaken  = 1'b0;
    chk("redir_valid", 32'(oValid), 32'd0);
    chk("redir_ir", 32'(oInstruction), 32'(NOP_IR));
    chk("redir_addr", 32'(oAddress), 32'(tgt));
    step();
    chk("flush_valid", 32'(oValid), 32'd0);
    chk("flush_addr", 32'(oAddress), 32'(tgt));
  endtask

  initial begin
    rst = 1'b1;
    iStall = 1'b0;
    iBranchTaken = 1'b0;
    iBranchTarget = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_pc", 32'(oPC), 32'd0);
    chk("rst_addr", 32'(oAddress), 32'd0);
    chk("rst_ir", 32'(oInstruction), 32'(NOP_IR));
    rst = 1'b0;

    // BOOT edge: nothing captured
    step();
    chk("boot_valid", 32'(oValid), 32'd0);
    chk("boot_addr", 32'(oAddress), 32'd0);

    for (int i = 0; i < 8; i++) begin
      step();
      chk("seq_pc", 32'(oPC), i);
      chk("seq_valid", 32'(oValid), 32'd1);
      chk("seq_ir", 32'(oInstruction), 32'(mem(16'(i))));
    end

`ifdef IF_PREDECODE_JMP_EN
    chk("jmp_addr", 32'(oAddress), 32'd3);
    step();
    chk("jmp_pc", 32'(oPC), 32'd3);
    chk("jmp_valid", 32'(oValid), 32'd1);
`else
    chk("nojmp_addr", 32'(oAddress), 32'd8);
    redirect(16'd3);
    step();
    chk("br_pc", 32'(oPC), 32'd3);
    chk("br_valid", 32'(oValid), 32'd1);
`endif
    step();
    chk("after_pc", 32'(oPC), 32'd4);

    // Stall for three cycles while oPC=2
    redirect(16'd2);
    step();
    chk("pre_stall_pc", 32'(oPC), 32'd2);
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(oPC), 32'd2);
      chk("stall_ir", 32'(oInstruction), 32'(mem(16'd2)));
      chk("stall_addr", 32'(oAddress), 32'd3);
      chk("stall_valid", 32'(oValid), 32'd1);
    end
    iStall = 1'b0;
    step();
    chk("resume_pc", 32'(oPC), 32'd3);

    // Redirect with stall; stall also held through FLUSH
    iStall = 1'b1;
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0005;
    step();
    iBranchTaken = 1'b0;
    chk("bs_valid", 32'(oValid), 32'd0);
    chk("bs_addr", 32'(oAddress), 32'h5);
    step();
    chk("bs_flush_valid", 32'(oValid), 32'd0);
    iStall = 1'b0;
    step();
    chk("bs_pc", 32'(oPC), 32'h5);
    chk("bs_pc_valid", 32'(oValid), 32'd1);

    // PC wrap
    redirect(16'hFFFF);
    step();
    chk("wrap_pc0", 32'(oPC), 32'hFFFF);
    chk("wrap_ir0", 32'(oInstruction), 32'(mem(16'hFFFF)));
    step();
    chk("wrap_pc1", 32'(oPC), 32'h0000);
    chk("wrap_valid", 32'(oValid), 32'd1);

    // Asynchronous reset in the middle of FLUSH
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0010;
    step();
    iBranchTaken = 1'b0;
    chk("pre_ar_addr", 32'(oAddress), 32'h10);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(oValid), 32'd0);
    chk("ar_pc", 32'(oPC), 32'd0);
    chk("ar_addr", 32'(oAddress), 32'd0);
    chk("ar_ir", 32'(oInstruction), 32'(NOP_IR));
    step();
    rst = 1'b0;

    // Redirect during BOOT is ignored
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0009;
    step();
    iBranchTaken = 1'b0;
    chk("boot2_valid", 32'(oValid), 32'd0);
    chk("boot2_addr", 32'(oAddress), 32'd0);
    step();
    chk("boot2_pc", 32'(oPC), 32'd0);
    chk("boot2_pvalid", 32'(oValid), 32'd1);
    chk("boot2_ir", 32'(oInstruction), 32'(mem(16'd0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
